// File: rtl/tmr_mac_sequencer_if.sv
// Operand stream, multiplier link and status bundle of the TMR dot-product sequencer.
// Handshake: a pair moves on a rising edge only when in_valid and in_ready are both high; in_ready never depends on in_valid.
interface tmr_mac_sequencer_if #(
  parameter int N     = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_x;
  logic [N-1:0]     in_w;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [N-1:0]     mul_result;
  logic             mul_invalid;
  logic             mul_ovf;
  logic             busy;
  logic             done;
  logic [N-1:0]     acc;
  logic             ovf;
  logic             fault;
  logic [7:0]       retry_cnt;
  logic [1:0]       state;

  modport slave (
    input  start, len, in_valid, in_x, in_w, mul_result, mul_invalid, mul_ovf,
    output in_ready, mul_a, mul_b, busy, done, acc, ovf, fault, retry_cnt, state
  );

  modport master (
    output start, len, in_valid, in_x, in_w, mul_result, mul_invalid, mul_ovf,
    input  in_ready, mul_a, mul_b, busy, done, acc, ovf, fault, retry_cnt, state
  );
endinterface

// File: rtl/tmr_mac_sequencer.sv
// Drives the shared TMR multiplier over one neuron's operand pairs, re-issuing on
// invalid votes and accumulating products with signed saturation.
module tmr_mac_sequencer #(
  parameter int N         = 16,
  parameter int INTBITS   = 6,
  parameter int FRACBITS  = 10,
  parameter int MAX_RETRY = 2,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tmr_mac_sequencer_if.slave bus
);

  if (INTBITS + FRACBITS != N) begin : g_format_mismatch
    $error("INTBITS + FRACBITS must equal N");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [1:0]       state;
  logic [N-1:0]     acc_r;
  logic [N-1:0]     mul_a_r;
  logic [N-1:0]     mul_b_r;
  logic             ovf_r;
  logic             fault_r;
  logic [7:0]       retry_r;
  logic [LEN_W-1:0] term_cnt;
  logic [LEN_W-1:0] len_r;
  logic [RW-1:0]    try_cnt;

  logic [N:0]       sum;
  logic             sat_pos;
  logic             sat_neg;
  logic [N-1:0]     sum_sat;
  logic [LEN_W-1:0] term_nxt;
  logic             retry_now;

  // One extra sign bit makes the overflow direction visible in the top two bits.
  always_comb begin
    sum      = {acc_r[N-1], acc_r} + {bus.mul_result[N-1], bus.mul_result};
    sat_pos  = ~sum[N] &  sum[N-1];
    sat_neg  =  sum[N] & ~sum[N-1];
    sum_sat  = sum[N-1:0];
    if (sat_pos) sum_sat = {1'b0, {(N-1){1'b1}}};
    if (sat_neg) sum_sat = {1'b1, {(N-1){1'b0}}};
    term_nxt  = term_cnt + 1'b1;
    retry_now = bus.mul_invalid && (try_cnt < RW'(MAX_RETRY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_r    <= '0;
      mul_a_r  <= '0;
      mul_b_r  <= '0;
      ovf_r    <= 1'b0;
      fault_r  <= 1'b0;
      retry_r  <= '0;
      term_cnt <= '0;
      len_r    <= '0;
      try_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_r    <= '0;
            ovf_r    <= 1'b0;
            fault_r  <= 1'b0;
            retry_r  <= '0;
            term_cnt <= '0;
            len_r    <= bus.len;
            state    <= (bus.len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (bus.in_valid) begin
            mul_a_r <= bus.in_x;
            mul_b_r <= bus.in_w;
            try_cnt <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          // Operands stay put, so staying here re-evaluates the same product.
          if (retry_now) begin
            try_cnt <= try_cnt + 1'b1;
            if (retry_r != 8'hFF) retry_r <= retry_r + 8'd1;
          end else begin
            acc_r    <= sum_sat;
            ovf_r    <= ovf_r | bus.mul_ovf | sat_pos | sat_neg;
            fault_r  <= fault_r | bus.mul_invalid;
            term_cnt <= term_nxt;
            state    <= (term_nxt == len_r) ? DONE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == FETCH);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.acc       = acc_r;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.ovf       = ovf_r;
  assign bus.fault     = fault_r;
  assign bus.retry_cnt = retry_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_tmr_mac_sequencer.sv
// Directed bench for tmr_mac_sequencer with a behavioural fixed-point multiplier
// whose vote can be forced invalid on the first or on every evaluation of a product.
module tb_tmr_mac_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  int   inv_mode;   // 0: always valid, 1: first MUL sample invalid, 2: always invalid
  logic force_ovf;
  int   mul_cycles;

  logic [15:0] xs [8];
  logic [15:0] ws [8];
  logic [15:0] exp_q [$];

  logic signed [31:0] prod;

  tmr_mac_sequencer_if #(.N(16), .LEN_W(8)) bus ();

  tmr_mac_sequencer #(
    .N(16), .INTBITS(6), .FRACBITS(10), .MAX_RETRY(2), .LEN_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // multiplier model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mul_cycles <= 0;
    else if (bus.in_valid && bus.in_ready) mul_cycles <= 0;
    else if (bus.busy && !bus.in_ready && !bus.done) mul_cycles <= mul_cycles + 1;
  end

  assign prod            = $signed(bus.mul_a) * $signed(bus.mul_b);
  assign bus.mul_invalid = (inv_mode == 2) || (inv_mode == 1 && mul_cycles == 0);
  assign bus.mul_result  = bus.mul_invalid ? 16'h1234 : prod[25:10];
  assign bus.mul_ovf     = force_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one dot product over xs/ws; lat is done-cycle minus start-cycle, -1 on timeout.
  task automatic run_dot(input int n, input int stall_cycles, input bit pulse_start,
                         output int lat, output logic [15:0] acc_out);
    int t0;
    int idx;
    int stall;
    bit hs;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = 8'(n);
    bus.in_valid = 1'b0;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    idx   = 0;
    stall = stall_cycles;
    lat   = -1;
    acc_out = 16'hxxxx;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        lat     = cyc - t0;
        acc_out = bus.acc;
        break;
      end
      bus.start = pulse_start && (k == 0);
      if (pulse_start && k == 0) bus.len = 8'd5;
      if (bus.in_ready && stall > 0) begin
        bus.in_valid = 1'b0;
        stall--;
      end else begin
        bus.in_valid = (idx < n);
        if (idx < n) begin
          bus.in_x = xs[idx];
          bus.in_w = ws[idx];
        end
      end
      hs = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (hs) idx++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  int          lat;
  logic [15:0] got_acc;

  initial begin
    cyc = 0; checks = 0; failures = 0;
    inv_mode = 0; force_ovf = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_x = '0; bus.in_w = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  bus.busy, 0);
    check_eq("rst_ready", bus.in_ready, 0);
    check_eq("rst_done",  bus.done, 0);
    check_eq("rst_acc",   bus.acc, 0);
    check_eq("rst_flags", {bus.ovf, bus.fault, bus.retry_cnt}, 0);
    check_eq("rst_mul",   {bus.mul_a, bus.mul_b}, 0);
    rst_n = 1'b1;

    // basic: 1.0 + 2.0 - 0.5 = 2.5
    xs[0] = 16'h0400; xs[1] = 16'h0800; xs[2] = 16'hFE00;
    ws[0] = 16'h0400; ws[1] = 16'h0400; ws[2] = 16'h0400;
    exp_q.push_back(16'h0A00);
    run_dot(3, 0, 1'b0, lat, got_acc);
    check_eq("basic_acc", got_acc, exp_q.pop_front());
    check_eq("basic_lat", lat, 7);
    check_eq("basic_flags", {bus.ovf, bus.fault, bus.retry_cnt}, 0);
    check_eq("basic_mul_hold", {bus.mul_a, bus.mul_b}, {16'hFE00, 16'h0400});
    repeat (2) @(negedge clk);
    check_eq("basic_acc_held", bus.acc, 16'h0A00);
    check_eq("basic_done_pulse", {bus.done, bus.busy}, 0);

    // one invalid vote, recovered product 3.0
    inv_mode = 1;
    xs[0] = 16'h0C00; ws[0] = 16'h0400;
    exp_q.push_back(16'h0C00);
    run_dot(1, 0, 1'b0, lat, got_acc);
    check_eq("retry_acc", got_acc, exp_q.pop_front());
    check_eq("retry_lat", lat, 4);
    check_eq("retry_cnt", bus.retry_cnt, 1);
    check_eq("retry_fault", bus.fault, 0);

    // persistent invalid: third sample accepted as is
    inv_mode = 2;
    exp_q.push_back(16'h1234);
    run_dot(1, 0, 1'b0, lat, got_acc);
    check_eq("fault_acc", got_acc, exp_q.pop_front());
    check_eq("fault_lat", lat, 5);
    check_eq("fault_cnt", bus.retry_cnt, 2);
    check_eq("fault_flag", bus.fault, 1);
    inv_mode = 0;

    // positive saturation
    xs[0] = 16'h6000; xs[1] = 16'h6000; ws[0] = 16'h0400; ws[1] = 16'h0400;
    exp_q.push_back(16'h7FFF);
    run_dot(2, 0, 1'b0, lat, got_acc);
    check_eq("satp_acc", got_acc, exp_q.pop_front());
    check_eq("satp_ovf", bus.ovf, 1);
    check_eq("satp_fault_cleared", bus.fault, 0);

    // negative saturation
    xs[0] = 16'hA000; xs[1] = 16'hA000;
    exp_q.push_back(16'h8000);
    run_dot(2, 0, 1'b0, lat, got_acc);
    check_eq("satn_acc", got_acc, exp_q.pop_front());
    check_eq("satn_ovf", bus.ovf, 1);
    check_eq("satn_lat", lat, 5);

    // multiplier overflow flag alone
    force_ovf = 1'b1;
    xs[0] = 16'h0400; ws[0] = 16'h0800;
    exp_q.push_back(16'h0800);
    run_dot(1, 0, 1'b0, lat, got_acc);
    check_eq("movf_acc", got_acc, exp_q.pop_front());
    check_eq("movf_ovf", bus.ovf, 1);
    force_ovf = 1'b0;

    // len = 0
    exp_q.push_back(16'h0000);
    run_dot(0, 0, 1'b0, lat, got_acc);
    check_eq("len0_acc", got_acc, exp_q.pop_front());
    check_eq("len0_lat", lat, 1);
    check_eq("len0_flags", {bus.ovf, bus.fault, bus.retry_cnt}, 0);

    // start pulsed during FETCH is ignored: 0.5*2 + (-1)*1 = 0
    xs[0] = 16'h0200; ws[0] = 16'h0800; xs[1] = 16'hFC00; ws[1] = 16'h0400;
    exp_q.push_back(16'h0000);
    run_dot(2, 0, 1'b1, lat, got_acc);
    check_eq("ign_acc", got_acc, exp_q.pop_front());
    check_eq("ign_lat", lat, 5);

    // 3 stall cycles in FETCH: 1.5*1 + 0.25*4 = 2.5
    xs[0] = 16'h0600; ws[0] = 16'h0400; xs[1] = 16'h0100; ws[1] = 16'h1000;
    exp_q.push_back(16'h0A00);
    run_dot(2, 3, 1'b0, lat, got_acc);
    check_eq("stall_acc", got_acc, exp_q.pop_front());
    check_eq("stall_lat", lat, 8);

    // reset during MUL of term 2 of 4
    force_ovf = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd4;
    bus.in_valid = 1'b1; bus.in_x = 16'h0400; bus.in_w = 16'h0400;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_acc", bus.acc, 16'h0400);
    check_eq("pre_rst_ovf", bus.ovf, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_acc", bus.acc, 0);
    check_eq("midrst_flags", {bus.ovf, bus.fault, bus.done}, 0);
    check_eq("midrst_mul", {bus.mul_a, bus.mul_b}, 0);
    bus.in_valid = 1'b0;
    force_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // fresh run after reset: 1+2+3+4 = 10.0
    xs[0] = 16'h0400; xs[1] = 16'h0800; xs[2] = 16'h0C00; xs[3] = 16'h1000;
    ws[0] = 16'h0400; ws[1] = 16'h0400; ws[2] = 16'h0400; ws[3] = 16'h0400;
    exp_q.push_back(16'h2800);
    run_dot(4, 0, 1'b0, lat, got_acc);
    check_eq("post_rst_acc", got_acc, exp_q.pop_front());
    check_eq("post_rst_lat", lat, 9);
    check_eq("post_rst_flags", {bus.ovf, bus.fault, bus.retry_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
